// File: rtl/event_sleep_ctrl.sv
// Sleep/wake sequencer: drains and halts the core, gates its clock, then restores the clock and fetch in order on wake.
// Latency: fetch drops 1 cycle after a sleep request edge; after wake in SLEEP, clock returns at +1 and fetch at +1+WAKE_DLY.
// Backpressure: waits in DRAIN for core_busy_i to fall, for at most DRAIN_TIMEOUT cycles, then aborts with sticky drain_err_o.
module event_sleep_ctrl #(
    parameter int WAKE_DLY      = 4,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int CNT_W         = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             sleep_req_i,
    input  logic [31:0]      irq_pending_i,
    input  logic [31:0]      irq_enable_i,
    input  logic [31:0]      event_pending_i,
    input  logic [31:0]      event_enable_i,
    input  logic             core_busy_i,
    output logic             fetch_enable_o,
    output logic             clock_en_o,
    output logic [2:0]       sleep_status_o,
    output logic             drain_err_o,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] sleep_count_o
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_SLEEP = 3'd2,
        ST_WAKE  = 3'd3
    } state_t;

    // Counters start at 0 on the first cycle of their state, so the last cycle is N-1.
    localparam logic [15:0]      DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);
    localparam logic [7:0]       WAKE_LAST  = 8'(WAKE_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t      state;
    state_t      state_n;
    logic        sleep_req_q;
    logic [15:0] drain_cnt;
    logic [7:0]  wake_cnt;
    logic        wake;
    logic        req_edge;
    logic        err_set;
    logic        sleep_entry;

    assign wake     = (|(irq_pending_i & irq_enable_i)) | (|(event_pending_i & event_enable_i));
    assign req_edge = sleep_req_i & ~sleep_req_q;

    // Next-state decode; in DRAIN a wake beats busy-clear, which beats timeout.
    always_comb begin
        state_n     = state;
        err_set     = 1'b0;
        sleep_entry = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (req_edge && !wake) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wake) begin
                    state_n = ST_RUN;
                end else if (!core_busy_i) begin
                    state_n     = ST_SLEEP;
                    sleep_entry = 1'b1;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_n = ST_RUN;
                    err_set = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (wake) begin
                    state_n = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    // State register with outputs registered from the next state so they track it exactly.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state          <= ST_RUN;
            fetch_enable_o <= 1'b1;
            clock_en_o     <= 1'b1;
            sleep_status_o <= 3'd0;
        end else begin
            state          <= state_n;
            fetch_enable_o <= (state_n == ST_RUN);
            clock_en_o     <= (state_n != ST_SLEEP);
            sleep_status_o <= state_n;
        end
    end

    // Per-state cycle counters, held at zero outside their own state.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            drain_cnt <= 16'd0;
            wake_cnt  <= 8'd0;
        end else begin
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 16'd1 : 16'd0;
            wake_cnt  <= (state == ST_WAKE)  ? wake_cnt + 8'd1   : 8'd0;
        end
    end

    // Request edge detect, sticky drain error (set wins over clear) and saturating sleep counter.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sleep_req_q   <= 1'b0;
            drain_err_o   <= 1'b0;
            sleep_count_o <= '0;
        end else begin
            sleep_req_q <= sleep_req_i;
            if (err_set) begin
                drain_err_o <= 1'b1;
            end else if (err_clr_i) begin
                drain_err_o <= 1'b0;
            end
            if (sleep_entry && (sleep_count_o != CNT_MAX)) begin
                sleep_count_o <= sleep_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_event_sleep_ctrl.sv
// Bench for event_sleep_ctrl: directed scenarios followed by random traffic.
// Expected outputs come from a time-stamped mode model and are queued per cycle.
// A separate monitor pops one expectation after every clock edge and compares it.
module tb_event_sleep_ctrl;

    localparam int WD = 4;
    localparam int DT = 64;
    localparam int CW = 2;
    localparam int CNT_SAT = (1 << CW) - 1;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_SLEEP = 2;
    localparam int M_WAKE  = 3;

    typedef struct packed {
        logic          fetch;
        logic          clk_en;
        logic [2:0]    status;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          HCLK;
    logic          HRESET;
    logic          sleep_req_i;
    logic [31:0]   irq_pending_i;
    logic [31:0]   irq_enable_i;
    logic [31:0]   event_pending_i;
    logic [31:0]   event_enable_i;
    logic          core_busy_i;
    logic          fetch_enable_o;
    logic          clock_en_o;
    logic [2:0]    sleep_status_o;
    logic          drain_err_o;
    logic          err_clr_i;
    logic [CW-1:0] sleep_count_o;

    event_sleep_ctrl #(.WAKE_DLY(WD), .DRAIN_TIMEOUT(DT), .CNT_W(CW)) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .sleep_req_i    (sleep_req_i),
        .irq_pending_i  (irq_pending_i),
        .irq_enable_i   (irq_enable_i),
        .event_pending_i(event_pending_i),
        .event_enable_i (event_enable_i),
        .core_busy_i    (core_busy_i),
        .fetch_enable_o (fetch_enable_o),
        .clock_en_o     (clock_en_o),
        .sleep_status_o (sleep_status_o),
        .drain_err_o    (drain_err_o),
        .err_clr_i      (err_clr_i),
        .sleep_count_o  (sleep_count_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // stimulus state, applied by tick()
    bit          s_rst;
    bit          s_req;
    logic [31:0] s_ip, s_ie, s_ep, s_ee;
    bit          s_busy;
    bit          s_clr;

    // reference model: current mode and the cycle at which it was entered
    int m_mode;
    int m_since;
    int m_cnt;
    bit m_err;
    bit m_prev;
    int cyc;

    exp_t sb_q[$];
    int   n_vec;
    int   n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit   wk;
        bit   rise;
        bit   eset;
        int   nxt;
        exp_t e;
        if (s_rst) begin
            m_mode  = M_RUN;
            m_err   = 1'b0;
            m_cnt   = 0;
            m_prev  = 1'b0;
            m_since = cyc + 1;
        end else begin
            wk     = ((s_ip & s_ie) != 0) || ((s_ep & s_ee) != 0);
            rise   = s_req && !m_prev;
            m_prev = s_req;
            nxt    = m_mode;
            eset   = 1'b0;
            case (m_mode)
                M_RUN:   if (rise && !wk) nxt = M_DRAIN;
                M_DRAIN: begin
                    if (wk) nxt = M_RUN;
                    else if (!s_busy) begin
                        nxt   = M_SLEEP;
                        m_cnt = (m_cnt >= CNT_SAT) ? CNT_SAT : m_cnt + 1;
                    end else if (cyc - m_since + 1 >= DT) begin
                        nxt  = M_RUN;
                        eset = 1'b1;
                    end
                end
                M_SLEEP: if (wk) nxt = M_WAKE;
                default: if (cyc - m_since + 1 >= WD) nxt = M_RUN;
            endcase
            if (eset) m_err = 1'b1;
            else if (s_clr) m_err = 1'b0;
            if (nxt != m_mode) begin
                m_mode  = nxt;
                m_since = cyc + 1;
            end
        end
        cyc++;
        e.fetch  = (m_mode == M_RUN);
        e.clk_en = (m_mode != M_SLEEP);
        e.status = 3'(m_mode);
        e.err    = m_err;
        e.cnt    = CW'(m_cnt);
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge HCLK);
            HRESET          = s_rst;
            sleep_req_i     = s_req;
            irq_pending_i   = s_ip;
            irq_enable_i    = s_ie;
            event_pending_i = s_ep;
            event_enable_i  = s_ee;
            core_busy_i     = s_busy;
            err_clr_i       = s_clr;
            model_step();
        end
    endtask

    // monitor: one expectation per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("fetch_enable", 32'(fetch_enable_o), 32'(e.fetch));
                check("clock_en", 32'(clock_en_o), 32'(e.clk_en));
                check("sleep_status", 32'(sleep_status_o), 32'(e.status));
                check("drain_err", 32'(drain_err_o), 32'(e.err));
                check("sleep_count", 32'(sleep_count_o), 32'(e.cnt));
                check("order_fetch_without_clock", 32'(fetch_enable_o & ~clock_en_o), 32'd0);
            end
        end
    end

    initial begin
        int busy_mode;
        n_vec = 0; n_bad = 0; cyc = 0;
        m_mode = M_RUN; m_since = 0; m_cnt = 0; m_err = 0; m_prev = 0;
        s_rst = 1; s_req = 0; s_ip = 0; s_ie = 0; s_ep = 0; s_ee = 0; s_busy = 0; s_clr = 0;
        HRESET = 1; sleep_req_i = 0; irq_pending_i = 0; irq_enable_i = 0;
        event_pending_i = 0; event_enable_i = 0; core_busy_i = 0; err_clr_i = 0;

        // reset state
        tick(2);
        s_rst = 0;
        tick(1);

        // basic sleep/wake, wake drops during WAKE
        s_req = 1; tick(3);
        s_req = 0; tick(2);
        s_ip = 32'h1; s_ie = 32'h1; tick(1);
        s_ip = 0; tick(8);

        // masked event does not wake, enabling it does
        s_req = 1; tick(3);
        s_req = 0;
        s_ep = 32'h80; s_ee = 32'h00; tick(20);
        s_ee = 32'h80; tick(1);
        s_ep = 0; s_ee = 0; tick(8);

        // drain timeout, then error clear
        s_busy = 1; s_req = 1; tick(70);
        s_req = 0; s_clr = 1; tick(1);
        s_clr = 0; tick(2);

        // request while a wake is pending is dropped
        s_ip = 32'h4; s_ie = 32'h4; s_req = 1; tick(5);
        s_ip = 0; s_req = 0; tick(2);

        // wake arriving during DRAIN
        s_busy = 1; s_req = 1; tick(3);
        s_ip = 32'h1; s_ie = 32'h1; tick(1);
        s_ip = 0; tick(7);
        s_busy = 0; s_req = 0; tick(2);

        // reset in the middle of WAKE
        s_req = 1; tick(3);
        s_ip = 32'h1; tick(2);
        s_ip = 0; s_rst = 1; tick(1);
        s_rst = 0; s_req = 0; tick(2);

        // five full sleeps saturate the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            s_req = 1; tick(3);
            s_ip = 32'h1; tick(1);
            s_ip = 0; s_req = 0; tick(6);
        end

        // random traffic
        busy_mode = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 150 == 0) busy_mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) s_req = ~s_req;
            s_busy = (busy_mode == 0) ? 1'b0 :
                     (busy_mode == 1) ? 1'($urandom_range(0, 1)) :
                                        ($urandom_range(0, 39) != 0);
            s_ip  = ($urandom_range(0, 24) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            s_ie  = $urandom;
            s_ep  = ($urandom_range(0, 24) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            s_ee  = $urandom;
            s_clr = ($urandom_range(0, 29) == 0);
            s_rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        s_rst = 0; s_ip = 0; s_ep = 0; s_clr = 0;
        tick(2);

        repeat (3) @(posedge HCLK);
        #2;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
